// File: rtl/irq_enc4t2_if.sv
// Request/grant bundle between the requesting lines, the encoder and its consumer.
// The master side drives requests, enable and acknowledge; the slave side returns the grant.
interface irq_enc4t2_if;
    logic       I0;
    logic       I1;
    logic       I2;
    logic       I3;
    logic       En;
    logic       Ack;
    logic       V;
    logic       Q0;
    logic       Q1;
    logic [3:0] Pend;

    modport master (
        output I0, I1, I2, I3, En, Ack,
        input  V, Q0, Q1, Pend
    );

    modport slave (
        input  I0, I1, I2, I3, En, Ack,
        output V, Q0, Q1, Pend
    );
endinterface

// File: rtl/irq_enc4t2.sv
// Registered 4-to-2 request encoder: sticky edge-captured pending bits, fixed priority
// (line 0 highest), and a valid/acknowledge grant whose index holds until retired.
module irq_enc4t2 (
    input  logic          clk,
    input  logic          rst_n,
    irq_enc4t2_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] req;
    logic [3:0] prev;
    logic [3:0] pend;
    logic [3:0] rise;
    logic [3:0] clr_mask;
    logic [1:0] idx;
    logic [1:0] top_idx;
    logic       v;

    assign req  = {bus.I3, bus.I2, bus.I1, bus.I0};
    assign rise = req & ~prev & {4{bus.En}};

    // Acknowledge only counts while a grant is presented.
    assign clr_mask = (state == GRANT && bus.Ack) ? (4'b0001 << idx) : 4'b0000;

    always_comb begin
        // NOTE: default first so every path assigns top_idx and no latch is inferred.
        top_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pend[i]) top_idx = 2'(i);
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            v     <= 1'b0;
            idx   <= 2'd0;
            pend  <= 4'b0000;
            // Lines held high through reset must fall and rise again to request.
            prev  <= 4'b1111;
        end else begin
            prev <= req;
            // A new edge on the line being cleared wins over the clear.
            pend <= (pend & ~clr_mask) | rise;

            case (state)
                IDLE: begin
                    if (bus.En && |pend) begin
                        idx   <= top_idx;
                        v     <= 1'b1;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (bus.Ack) begin
                        v     <= 1'b0;
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (bus.En && |pend) begin
                        idx   <= top_idx;
                        v     <= 1'b1;
                        state <= GRANT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    v     <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.V    = v;
    assign bus.Q0   = idx[1];
    assign bus.Q1   = idx[0];
    assign bus.Pend = pend;
endmodule

// File: tb/tb_irq_enc4t2.sv
// Directed vector bench for irq_enc4t2: a per-cycle table of inputs and expected outputs,
// followed by hand-written async-reset and bounded-latency sequences.
module tb_irq_enc4t2;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    irq_enc4t2_if bus ();

    irq_enc4t2 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] req;      // {I3,I2,I1,I0}
        logic       en;
        logic       ack;
        logic       exp_v;
        logic [1:0] exp_q;    // {Q0,Q1}
        logic [3:0] exp_pend;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic en, input logic ack);
        bus.I0  = r[0];
        bus.I1  = r[1];
        bus.I2  = r[2];
        bus.I3  = r[3];
        bus.En  = en;
        bus.Ack = ack;
    endtask

    task automatic add(input logic [3:0] r, input logic en, input logic ack,
                       input logic ev, input logic [1:0] eq, input logic [3:0] ep);
        vec_t v;
        v.req      = r;
        v.en       = en;
        v.ack      = ack;
        v.exp_v    = ev;
        v.exp_q    = eq;
        v.exp_pend = ep;
        vecs.push_back(v);
    endtask

    task automatic check_outputs(input string tag, input logic ev, input logic [1:0] eq,
                                 input logic [3:0] ep);
        check({tag, " V"},    {7'd0, bus.V},          {7'd0, ev});
        check({tag, " Q"},    {6'd0, bus.Q0, bus.Q1}, {6'd0, eq});
        check({tag, " Pend"}, {4'd0, bus.Pend},       {4'd0, ep});
    endtask

    initial begin
        bit got_v;

        // Reset & idle: I2 held high through reset release must not request.
        add(4'b0100, 1, 0, 0, 2'b00, 4'b0000);
        add(4'b0100, 1, 0, 0, 2'b00, 4'b0000);
        add(4'b0000, 1, 0, 0, 2'b00, 4'b0000);
        // Single request on line 2.
        add(4'b0100, 1, 0, 0, 2'b00, 4'b0100);
        add(4'b0000, 1, 0, 1, 2'b10, 4'b0100);
        add(4'b0000, 1, 0, 1, 2'b10, 4'b0100);
        add(4'b0000, 1, 1, 0, 2'b10, 4'b0000);
        add(4'b0000, 1, 0, 0, 2'b10, 4'b0000);
        // Priority and freeze: I3+I1 together, then I0 during the grant.
        add(4'b1010, 1, 0, 0, 2'b10, 4'b1010);
        add(4'b1010, 1, 0, 1, 2'b01, 4'b1010);
        add(4'b1011, 1, 0, 1, 2'b01, 4'b1011);
        add(4'b0000, 1, 1, 0, 2'b01, 4'b1001);
        add(4'b0000, 1, 0, 1, 2'b00, 4'b1001);
        add(4'b0000, 1, 1, 0, 2'b00, 4'b1000);
        add(4'b0000, 1, 0, 1, 2'b11, 4'b1000);
        add(4'b0000, 1, 1, 0, 2'b11, 4'b0000);
        add(4'b0000, 1, 0, 0, 2'b11, 4'b0000);
        // Enable gating: edge discarded with En low.
        add(4'b0010, 0, 0, 0, 2'b11, 4'b0000);
        add(4'b0000, 0, 0, 0, 2'b11, 4'b0000);
        // Pend=0010 held with En low, then granted once En rises; En low keeps the grant.
        add(4'b0010, 1, 0, 0, 2'b11, 4'b0010);
        add(4'b0000, 0, 0, 0, 2'b11, 4'b0010);
        add(4'b0000, 0, 0, 0, 2'b11, 4'b0010);
        add(4'b0000, 1, 0, 1, 2'b01, 4'b0010);
        add(4'b0000, 0, 0, 1, 2'b01, 4'b0010);
        add(4'b0000, 1, 1, 0, 2'b01, 4'b0000);
        add(4'b0000, 1, 0, 0, 2'b01, 4'b0000);
        // Set-wins collision on line 3.
        add(4'b1000, 1, 0, 0, 2'b01, 4'b1000);
        add(4'b0000, 1, 0, 1, 2'b11, 4'b1000);
        add(4'b1000, 1, 1, 0, 2'b11, 4'b1000);
        add(4'b0000, 1, 0, 1, 2'b11, 4'b1000);
        add(4'b0000, 1, 1, 0, 2'b11, 4'b0000);
        add(4'b0000, 1, 0, 0, 2'b11, 4'b0000);
        // Ack while idle is ignored.
        for (int i = 0; i < 5; i++) add(4'b0000, 1, 1, 0, 2'b11, 4'b0000);
        // Ack held high with all four pending: one retire every two cycles.
        add(4'b1111, 1, 1, 0, 2'b11, 4'b1111);
        add(4'b1111, 1, 1, 1, 2'b00, 4'b1111);
        add(4'b1111, 1, 1, 0, 2'b00, 4'b1110);
        add(4'b1111, 1, 1, 1, 2'b01, 4'b1110);
        add(4'b1111, 1, 1, 0, 2'b01, 4'b1100);
        add(4'b1111, 1, 1, 1, 2'b10, 4'b1100);
        add(4'b1111, 1, 1, 0, 2'b10, 4'b1000);
        add(4'b1111, 1, 1, 1, 2'b11, 4'b1000);
        add(4'b1111, 1, 1, 0, 2'b11, 4'b0000);
        add(4'b0000, 1, 0, 0, 2'b11, 4'b0000);

        rst_n = 1'b0;
        drive(4'b0100, 1'b1, 1'b0);
        #1;
        check_outputs("reset", 1'b0, 2'b00, 4'b0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].req, vecs[i].en, vecs[i].ack);
            @(posedge clk);
            #1;
            check_outputs($sformatf("row%0d", i), vecs[i].exp_v, vecs[i].exp_q, vecs[i].exp_pend);
        end

        // Async reset in the middle of a grant on line 2.
        @(negedge clk);
        drive(4'b0100, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check_outputs("mid_pend", 1'b0, 2'b11, 4'b0100);
        @(negedge clk);
        drive(4'b0000, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check_outputs("mid_grant", 1'b1, 2'b10, 4'b0100);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("async_rst", 1'b0, 2'b00, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Bounded wait for a grant after reset release.
        @(negedge clk);
        drive(4'b0010, 1'b1, 1'b0);
        @(negedge clk);
        drive(4'b0000, 1'b1, 1'b0);
        got_v = 1'b0;
        for (int c = 0; c < 6 && !got_v; c++) begin
            @(posedge clk);
            #1;
            got_v = bus.V;
        end
        check("post_rst_grant_seen", {7'd0, got_v}, 8'd1);
        check("post_rst_grant_idx", {6'd0, bus.Q0, bus.Q1}, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/irq_enc4t2.md
# irq_enc4t2

Registered 4-to-2 request encoder with valid/acknowledge handshake for the CPU datapath. It captures rising edges on four request lines and holds them as sticky pending bits. It grants the highest-priority pending line and presents its 2-bit index, encoded in the same bit order the 2-to-4 decoder consumes. The index is held until the consumer acknowledges it.

## Interface
- No parameters; width is fixed at 4 request lines / 2-bit index.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- I0, I1, I2, I3  input  1 each  request lines; a rising edge on Ix requests service for line x.
- En  input  1  high: edges are captured and new grants are issued; low: both are frozen.
- Ack  input  1  consumer acknowledge; sampled only while V is high.
- V  output  1  grant valid.
- Q0  output  1  index MSB.
- Q1  output  1  index LSB.
  - Index n is driven as Q0 = n[1], Q1 = n[0].
  - Feeding Q0/Q1 into the 2-to-4 decoder's I0/I1 reproduces line n.
- Pend  output  4  pending bits; bit x is line x.

## Operation
- Edge detect: `prev[x]` registers Ix every cycle. An edge on line x is `Ix & ~prev[x]`.
- Capture: when En is high and an edge occurs on line x, Pend[x] is set. When En is low, edges are discarded and Pend is unchanged. `prev` is still updated while En is low.
- Priority is fixed: line 0 is highest and line 3 is lowest.
- FSM states: IDLE, GRANT, GAP.
  - IDLE: if En is high and Pend is nonzero, latch the highest-priority index into Q0/Q1, set V=1, and go to GRANT. Otherwise stay in IDLE.
  - GRANT: V=1 and Q0/Q1 are frozen. New pending bits, including higher-priority ones, do not change the index. En low does not abort a grant.
    - If Ack is sampled high: clear Pend[index], set V=0, go to GAP.
    - If Ack is low: stay in GRANT.
  - GAP: V=0 for exactly one cycle.
    - If En is high and Pend is nonzero after the clear: latch the new index, set V=1, go to GRANT.
    - Otherwise go to IDLE.
- Ack while V is low is ignored.
- Simultaneous set and clear on the same line (a new edge on line x in the cycle Ack clears x): set wins, and Pend[x] stays 1.
- Q0/Q1 keep their last granted value while V=0. They are only meaningful while V=1.
- Reset (async, any state, including mid-handshake):
  - state=IDLE, V=0, Q0=0, Q1=0, Pend=0000.
  - `prev` resets to 1111, so a line held high through reset does not produce a request. It must fall and rise again to request.

## Timing
- Request latency:
  - Ix is sampled 0 at edge t-1 and 1 at edge t, with En=1 → Pend[x]=1 after edge t.
  - From IDLE, V=1 with index x after edge t+1.
- Grant release: Ack sampled 1 at edge k while V=1 → V=0 and Pend[index]=0 after edge k.
- Back-to-back grants: if more work is pending, V=1 again after edge k+1. Minimum V-low gap between grants is one cycle.
- Ack held high continuously: one grant retires every 2 cycles.
- Reset is asynchronous: outputs go to reset values without waiting for clk. The first state update occurs on the first rising clk edge after rst_n is high.

## Test plan
- Reset and idle:
  - Assert rst_n=0 mid-GRANT → V=0, Q0/Q1=00, Pend=0000 immediately, without a clock edge.
  - I2 held 1 through reset release → no grant; Pend stays 0000.
- Single request:
  - Pulse I2 at edge t with En=1 → Pend=0100 after t.
  - V=1 with Q0Q1=10 after t+1.
  - Ack at edge t+3 → V=0 and Pend=0000 after t+3; state IDLE after t+4.
- Priority and freeze:
  - I3 and I1 rise at the same edge → grant index 01 first.
  - While V=1, I0 rises → Q0Q1 stays 01.
  - After Ack: one V-low cycle, then index 00, then index 11. Pend goes 1010 → 1011 → 1001 → 1000 → 0000 as each grant retires.
- Enable gating:
  - With En=0, pulse I1 → Pend stays 0000.
  - With Pend=0010 and En=0 from IDLE → no grant. Setting En=1 → V=1 with index 01 one cycle later.
- Set-wins collision: in GRANT on index 11, I3 rises in the Ack cycle → Pend[3] stays 1 and line 3 is re-granted after the one-cycle GAP.
- Ack hygiene: Ack=1 while V=0 for 5 cycles with Pend=0000 → no state change. Ack held 1 with Pend=1111 → indices 00, 01, 10, 11 each retire in 2 cycles.
